// File: rtl/reg_file.sv
// reg_file: REG_CNT x XLEN register file, x0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward WD to reads of the register being written.
module reg_file #(
  parameter int XLEN    = 32,
  parameter int REG_CNT = 32
) (
  input  logic            clk,
  input  logic            res,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  // x0 has no storage; reads of it are forced to zero below
  logic [XLEN-1:0] r_regs [1:REG_CNT-1];

  logic [XLEN-1:0] w_rd1_raw;
  logic [XLEN-1:0] w_rd2_raw;
  logic            w_wr_ok;
  logic            w_byp1;
  logic            w_byp2;

  // A write only lands on an existing, non-zero register
  assign w_wr_ok = (A3 != 5'd0) && (int'(A3) < REG_CNT);

  // Storage: async clear, otherwise write WD to A3 on every edge
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 1; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      for (int i = 1; i < REG_CNT; i++) begin
        if (A3 == 5'(i)) begin
          r_regs[i] <= WD;
        end
      end
    end
  end

  // Read muxes: stored contents, zero for x0 or absent registers
  always_comb begin
    w_rd1_raw = '0;
    w_rd2_raw = '0;
    for (int i = 1; i < REG_CNT; i++) begin
      if (A1 == 5'(i)) begin
        w_rd1_raw = r_regs[i];
      end
      if (A2 == 5'(i)) begin
        w_rd2_raw = r_regs[i];
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward the in-flight write to a matching read port
  always_comb begin
    w_byp1 = res && w_wr_ok && (A1 == A3);
    w_byp2 = res && w_wr_ok && (A2 == A3);
  end
`else
  // No forwarding: reads always see stored contents
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
  end
`endif

  // Output select: zero during reset, then bypass, then storage
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (res) begin
      RD1 = w_byp1 ? WD : w_rd1_raw;
      RD2 = w_byp2 ? WD : w_rd2_raw;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file
// against an array model of the architectural registers.
module tb_reg_file;

  localparam int XLEN = 32;

  logic            clk;
  logic            res;
  logic [4:0]      A1;
  logic [4:0]      A2;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;

  int checks;
  int errors;

  logic [XLEN-1:0] m [32];

  reg_file #(.XLEN(XLEN), .REG_CNT(32)) dut (
    .clk(clk),
    .res(res),
    .A1(A1),
    .A2(A2),
    .A3(A3),
    .WD(WD),
    .RD1(RD1),
    .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a);
    if (!res || a == 5'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (a == A3) return WD;
`endif
    return m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (res && A3 != 5'd0) m[A3] = WD;
    @(negedge clk);
  endtask

  task automatic test_reset();
    A1 = 5'd5; A2 = 5'd10; A3 = 5'd0; WD = '0;
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL reset_held rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
    wait (res === 1'b1);
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL reset_released rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    A3 = 5'd5; WD = 32'd42; A1 = 5'd0; A2 = 5'd0;
    step();
    A3 = 5'd0; A1 = 5'd5; A2 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'd42 || RD2 !== '0) begin
      errors++;
      $display("FAIL write_x5 rd1=%h rd2=%h want 2a 0", RD1, RD2);
    end
    A3 = 5'd10; WD = 32'd100;
    step();
    A3 = 5'd0; A1 = 5'd10; A2 = 5'd5;
    #1;
    checks++;
    if (RD1 !== 32'd100 || RD2 !== 32'd42) begin
      errors++;
      $display("FAIL write_x10 rd1=%h rd2=%h want 64 2a", RD1, RD2);
    end
  endtask

  task automatic test_x0();
    A3 = 5'd0; WD = 32'hDEADBEEF; A1 = 5'd0; A2 = 5'd0;
    step();
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL x0_zero rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
    A1 = 5'd5; A2 = 5'd10;
    #1;
    checks++;
    if (RD1 !== 32'd42 || RD2 !== 32'd100) begin
      errors++;
      $display("FAIL x0_no_clobber rd1=%h rd2=%h want 2a 64", RD1, RD2);
    end
    A1 = 5'd10; A2 = 5'd10;
    #1;
    checks++;
    if (RD1 !== RD2 || RD1 !== 32'd100) begin
      errors++;
      $display("FAIL same_addr rd1=%h rd2=%h want 64 64", RD1, RD2);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    A3 = 5'd0; A1 = 5'd10; A2 = 5'd5;
    #1;
    res = 1'b0;
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL async_clear rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
    res = 1'b1;
    model_clear();
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL stays_clear rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    A3 = 5'd7; WD = 32'h12345678; A1 = 5'd7; A2 = 5'd0;
    #1;
    checks++;
`ifdef REG_FILE_BYPASS_EN
    if (RD1 !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_pre rd1=%h want 12345678", RD1);
    end
`else
    if (RD1 !== '0) begin
      errors++;
      $display("FAIL nobypass_pre rd1=%h want 0", RD1);
    end
`endif
    @(negedge clk);
    if (res && A3 != 5'd0) m[A3] = WD;
    A3 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'h12345678) begin
      errors++;
      $display("FAIL fwd_post rd1=%h want 12345678", RD1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A3 = 5'd3; WD = 32'h55; A1 = 5'd3; A2 = 5'd7;
    #4;
    res = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL mid_reset rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
    @(negedge clk);
    model_clear();
    res = 1'b1;
    A3 = 5'd0;
    #1;
    checks++;
    if (RD1 !== '0 || RD2 !== '0) begin
      errors++;
      $display("FAIL write_discard rd1=%h rd2=%h want 0 0", RD1, RD2);
    end
    A3 = 5'd3; WD = 32'd77;
    step();
    A3 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'd77) begin
      errors++;
      $display("FAIL first_write rd1=%h want 4d", RD1);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    A1 = 5'd9; A2 = 5'd9; A3 = 5'd9;
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      WD = v;
      step();
    end
    A3 = 5'd0;
    #1;
    checks++;
    if (RD1 !== v || RD2 !== v) begin
      errors++;
      $display("FAIL last_write rd1=%h rd2=%h want %h", RD1, RD2, v);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    for (int k = 0; k < 300; k++) begin
      A1 = 5'($urandom_range(0, 31));
      A2 = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
      A3 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) A1 = A3;
      WD = $urandom;
      #1;
      e1 = exp_rd(A1);
      e2 = exp_rd(A2);
      checks++;
      if (RD1 !== e1 || RD2 !== e2) begin
        errors++;
        $display("FAIL rand a1=%0d a2=%0d a3=%0d rd1=%h rd2=%h want %h %h",
                 A1, A2, A3, RD1, RD2, e1, e2);
      end
      step();
    end
  endtask

  task automatic test_hold();
    A3 = 5'd0;
    for (int k = 0; k < 20; k++) begin
      WD = $urandom;
      step();
    end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      checks++;
      if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2)) begin
        errors++;
        $display("FAIL hold x%0d rd1=%h rd2=%h want %h %h",
                 i, RD1, RD2, exp_rd(A1), exp_rd(A2));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    res = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; WD = '0;
    fork
      begin
        #10;
        res = 1'b1;
      end
      test_reset();
    join
    test_basic();
    test_x0();
    test_async_reset();
    test_forward();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
